// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register offsets, STATUS bit positions and FSM encodings for io_uart
package io_uart_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_RXDATA  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;
  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_VALID  = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_OVR    = 5;
  localparam int ST_RX_FERR   = 6;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, full pushes and empty pops are ignored
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp];
  // storage array, written only on accepted pushes
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with TX FIFO and single-byte RX holding register
module io_uart import io_uart_pkg::*; #(
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DIV_W      = 16,
  parameter int          DIV_RESET  = 234
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  input  logic        io_wr_i,
  output logic [31:0] io_rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);
  tx_state_t        r_tx_state, w_tx_next;
  rx_state_t        r_rx_state, w_rx_next;
  logic [DIV_W-1:0] r_div, r_tx_cnt, r_rx_cnt, w_div_m1, w_half;
  logic [2:0]       r_tx_bit, r_rx_bit;
  logic [7:0]       r_tx_sh, r_rx_sh, r_rx_byte, w_fifo_data;
  logic             r_tx, r_rx_s1, r_rx_s2, r_rx_prev;
  logic             r_rx_valid, r_rx_ovr, r_rx_ferr, r_tx_ovf;
  logic             w_sel, w_we, w_push, w_full, w_empty, w_busy, w_tx_pop;
  logic             w_tx_tick, w_rx_tick, w_rx_done, w_rx_load;
  logic             w_clr_ovf, w_clr_ovr, w_clr_ferr, w_rx_clr;
  logic [1:0]       w_off;
  logic [31:0]      w_status;
  logic             w_unused;
  assign w_unused   = ^{io_addr_i[1:0], io_wdata_i[31:DIV_W]};
  assign w_sel      = io_addr_i[31:4] == BASE_ADDR[31:4];
  assign w_off      = io_addr_i[3:2];
  assign w_we       = w_sel && io_wr_i;
  assign w_push     = w_we && w_off == REG_TXDATA;
  assign w_rx_clr   = w_we && w_off == REG_RXDATA;
  assign w_clr_ovf  = w_we && w_off == REG_STATUS && io_wdata_i[ST_TX_OVF];
  assign w_clr_ovr  = w_we && w_off == REG_STATUS && io_wdata_i[ST_RX_OVR];
  assign w_clr_ferr = w_we && w_off == REG_STATUS && io_wdata_i[ST_RX_FERR];
  assign w_div_m1   = r_div - DIV_W'(1);
  assign w_half     = (r_div >> 1) == '0 ? DIV_W'(1) : r_div >> 1;
  assign w_busy     = r_tx_state != TX_IDLE || !w_empty;
  assign w_tx_pop   = r_tx_state == TX_IDLE && !w_empty;
  assign w_tx_tick  = r_tx_cnt == '0;
  assign w_rx_tick  = r_rx_cnt == '0;
  assign w_rx_done  = r_rx_state == RX_STOP && w_rx_tick;
  assign w_rx_load  = w_rx_done && r_rx_s2;
  assign uart_tx_o  = r_tx;

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .i_push(w_push), .i_data(io_wdata_i[7:0]),
    .i_pop(w_tx_pop), .o_data(w_fifo_data), .o_full(w_full), .o_empty(w_empty)
  );

  // status word and read mux; reads never change state
  always_comb begin
    w_status = '0;
    w_status[ST_TX_EMPTY] = w_empty;
    w_status[ST_TX_FULL]  = w_full;
    w_status[ST_TX_BUSY]  = w_busy;
    w_status[ST_RX_VALID] = r_rx_valid;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[ST_RX_OVR]   = r_rx_ovr;
    w_status[ST_RX_FERR]  = r_rx_ferr;
    io_rdata_o = !w_sel ? 32'h0 :
                 w_off == REG_STATUS  ? w_status :
                 w_off == REG_RXDATA  ? {24'h0, r_rx_byte} :
                 w_off == REG_BAUDDIV ? 32'(r_div) : 32'h0;
  end

  // TX next state: every non-idle state lasts until the bit counter expires
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_empty) w_tx_next = TX_START;
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      default:  if (w_tx_tick) w_tx_next = TX_IDLE;
    endcase
  end

  // RX next state: a high line at mid start bit is treated as a glitch
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      default:  if (w_rx_tick) w_rx_next = RX_IDLE;
    endcase
  end

  // FSM state registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx_state <= TX_IDLE;
      r_rx_state <= RX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
    end
  end

  // TX datapath; the line register lags the state by one cycle so the start bit
  // appears on the second edge after the write
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx     <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx <= r_tx_state == TX_START ? 1'b0 : r_tx_state == TX_DATA ? r_tx_sh[0] : 1'b1;
      if (w_tx_pop) begin
        r_tx_sh  <= w_fifo_data;
        r_tx_cnt <= w_div_m1;
        r_tx_bit <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        r_tx_cnt <= w_tx_tick ? w_div_m1 : r_tx_cnt - DIV_W'(1);
        if (w_tx_tick && r_tx_state == TX_DATA) begin
          r_tx_sh  <= r_tx_sh >> 1;
          r_tx_bit <= r_tx_bit + 3'd1;
        end
      end
    end
  end

  // RX synchronizer and datapath; the counter preloads the half-bit delay while idle
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_rx_s1   <= uart_rx_i;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= w_half - DIV_W'(1);
        r_rx_bit <= '0;
      end else begin
        r_rx_cnt <= w_rx_tick ? w_div_m1 : r_rx_cnt - DIV_W'(1);
        if (w_rx_tick && r_rx_state == RX_DATA) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
        end
      end
    end
  end

  // software-visible registers; hardware set events beat software clears
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_div      <= DIV_W'(DIV_RESET);
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      if (w_we && w_off == REG_BAUDDIV)
        r_div <= io_wdata_i[DIV_W-1:0] == '0 ? DIV_W'(1) : io_wdata_i[DIV_W-1:0];
      r_rx_byte  <= w_rx_load ? r_rx_sh : r_rx_byte;
      r_rx_valid <= w_rx_load || (r_rx_valid && !w_rx_clr);
      r_rx_ovr   <= (w_rx_load && r_rx_valid && !w_rx_clr) || (r_rx_ovr && !w_clr_ovr);
      r_rx_ferr  <= (w_rx_done && !r_rx_s2) || (r_rx_ferr && !w_clr_ferr);
      r_tx_ovf   <= (w_push && w_full) || (r_tx_ovf && !w_clr_ovf);
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: scoreboard bench for io_uart register reads and serial TX frames
module tb_io_uart;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic        clk = 1'b0, reset_i = 1'b0, io_wr_i = 1'b0, uart_rx_i = 1'b1, rd_req = 1'b0;
  logic [31:0] io_addr_i = '0, io_wdata_i = '0, io_rdata_o;
  logic        uart_tx_o;
  int          n_chk = 0, n_err = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];

  io_uart dut (
    .clk_i(clk), .reset_i(reset_i), .io_addr_i(io_addr_i), .io_wdata_i(io_wdata_i),
    .io_wr_i(io_wr_i), .io_rdata_o(io_rdata_o), .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(string nm, logic [31:0] addr, logic [31:0] exp);
    @(posedge clk); #1;
    io_addr_i = addr;
    rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    io_addr_i = '0;
  endtask

  task automatic wr(logic [3:0] off, logic [31:0] d);
    @(posedge clk); #1;
    io_addr_i = BASE | {28'h0, off};
    io_wdata_i = d;
    io_wr_i = 1'b1;
    @(posedge clk); #1;
    io_wr_i = 1'b0;
    io_addr_i = '0;
  endtask

  task automatic send_rx(logic [7:0] b, logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      uart_rx_i = f[i];
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1;
    uart_rx_i = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_tx_drain(string nm);
    for (int i = 0; i < 3000 && tx_q.size() > 0; i++) @(posedge clk);
    chk(nm, tx_q.size(), 0);
  endtask

  // register read monitor
  always @(negedge clk) begin
    if (rd_req) chk(rd_name_q.pop_front(), io_rdata_o, rd_q.pop_front());
  end

  // serial TX monitor, assumes 4 clk per bit; frames cut by reset are discarded
  initial begin
    logic [7:0] b;
    logic st, sp, ab;
    forever begin
      @(negedge uart_tx_o);
      if (!reset_i) continue;
      ab = 1'b0; st = 1'b1; sp = 1'b0; b = '0;
      for (int n = 1; n <= 39; n++) begin
        @(negedge clk);
        ab |= !reset_i;
        if (n == 3) st = uart_tx_o;
        else if (n == 39) sp = uart_tx_o;
        else if (n > 3 && (n - 3) % 4 == 0) b[(n - 3) / 4 - 1] = uart_tx_o;
      end
      if (ab) begin
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end else if (tx_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL tx_unexpected got byte %h expected none", b);
      end else chk("tx_frame", {22'h0, st, sp, b}, {22'h0, 1'b0, 1'b1, tx_q.pop_front()});
    end
  end

  initial begin
    logic bad;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    rd("rst_status", BASE | 32'h4, 32'h1);
    rd("rst_bauddiv", BASE | 32'hC, 32'd234);
    chk("rst_tx_idle", {31'h0, uart_tx_o}, 32'h1);
    rd("unselected", 32'h0050_0004, 32'h0);
    wr(4'hC, 32'h0);
    rd("baud_zero", BASE | 32'hC, 32'h1);
    wr(4'hC, 32'h4);
    rd("baud_4", BASE | 32'hC, 32'h4);
    rd("txdata_read", BASE, 32'h0);
    tx_q.push_back(8'h55);
    wr(4'h0, 32'h55);
    chk("tx_e0", {31'h0, uart_tx_o}, 32'h1);
    @(posedge clk); #1 chk("tx_e1", {31'h0, uart_tx_o}, 32'h1);
    @(posedge clk); #1 chk("tx_e2_start", {31'h0, uart_tx_o}, 32'h0);
    repeat (3) @(posedge clk); #1 chk("tx_e5_start", {31'h0, uart_tx_o}, 32'h0);
    @(posedge clk); #1 chk("tx_e6_bit0", {31'h0, uart_tx_o}, 32'h1);
    rd("tx_busy", BASE | 32'h4, 32'h5);
    wait_tx_drain("tx55_drain");
    repeat (5) @(posedge clk);
    rd("tx_idle", BASE | 32'h4, 32'h1);
    for (int i = 0; i <= 16; i++) tx_q.push_back(8'(i));
    @(posedge clk); #1;
    io_addr_i = BASE;
    io_wr_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      io_wdata_i = i;
      @(posedge clk); #1;
    end
    io_wr_i = 1'b0;
    io_addr_i = '0;
    rd("ovf_status", BASE | 32'h4, 32'h16);
    wr(4'h4, 32'h10);
    rd("ovf_clear", BASE | 32'h4, 32'h06);
    wait_tx_drain("ovf_drain");
    repeat (5) @(posedge clk);
    rd("ovf_idle", BASE | 32'h4, 32'h1);
    send_rx(8'hA3, 1'b1);
    rd("rx_valid", BASE | 32'h4, 32'h09);
    rd("rx_a3", BASE | 32'h8, 32'hA3);
    send_rx(8'h5C, 1'b1);
    rd("rx_5c", BASE | 32'h8, 32'h5C);
    rd("rx_overrun", BASE | 32'h4, 32'h29);
    send_rx(8'h3C, 1'b0);
    rd("rx_frame_err", BASE | 32'h4, 32'h69);
    rd("rx_ferr_keep", BASE | 32'h8, 32'h5C);
    @(posedge clk); #1 uart_rx_i = 1'b0;
    @(posedge clk); #1 uart_rx_i = 1'b1;
    repeat (12) @(posedge clk);
    rd("rx_glitch", BASE | 32'h4, 32'h69);
    wr(4'h8, 32'h0);
    rd("rx_clr_valid", BASE | 32'h4, 32'h61);
    wr(4'h4, 32'h60);
    rd("rx_clr_sticky", BASE | 32'h4, 32'h01);
    tx_q.push_back(8'h00);
    wr(4'h0, 32'h00);
    repeat (10) @(posedge clk);
    #1 reset_i = 1'b0;
    #1 chk("reset_tx_high", {31'h0, uart_tx_o}, 32'h1);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    rd("post_rst_status", BASE | 32'h4, 32'h1);
    rd("post_rst_baud", BASE | 32'hC, 32'd234);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      bad |= !uart_tx_o;
    end
    chk("post_rst_quiet", {31'h0, bad}, 32'h0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
- Memory-mapped UART peripheral that sits directly downstream of the processor's IO port (IO_memAddr/IO_memWData/IO_memWr/IO_memRData).
- Transmit path: a TX FIFO feeds an 8N1 serializer. Receive path: a single-byte 8N1 deserializer.
- Reads have no side effects, because the core drives the address continuously and has no read strobe.
- The baud divisor is software programmable.

Parameters:
- BASE_ADDR, 32'h0040_0000, block base address; the block decodes addr[31:4] == BASE_ADDR[31:4].
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2 and at least 2.
- DIV_W, 16, baud divisor width.
- DIV_RESET, 234, divisor after reset, in clk cycles per bit.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- io_addr_i  in  32  byte address from core IO_memAddr.
- io_wdata_i  in  32  write data from core IO_memWData.
- io_wr_i  in  1  write strobe, one cycle per store.
- io_rdata_o  out  32  read data to core IO_memRData.
- uart_tx_o  out  1  serial TX line, idle high.
- uart_rx_i  in  1  serial RX line, asynchronous to clk_i.

Behaviour:
- Register map (offset addr[3:2]); unused bits read 0; writes only occur when selected && io_wr_i.
  - 0x0 TXDATA: a write pushes wdata[7:0]; reads return 0.
  - 0x4 STATUS: bit0 tx_fifo_empty, bit1 tx_fifo_full, bit2 tx_busy, bit3 rx_valid, bit4 tx_overflow, bit5 rx_overrun, bit6 rx_frame_err. A write of 1 to bits 4/5/6 clears that bit; other bits ignore writes.
  - 0x8 RXDATA: reads return {24'b0, rx_byte}; any write clears rx_valid.
  - 0xC BAUDDIV: read/write divisor[DIV_W-1:0]; a written value of 0 is stored as 1.
- io_rdata_o: combinational from io_addr_i and registered state. It is 0 when the block is not selected.
- Reset values:
  - uart_tx_o = 1; FIFO empty; divisor = DIV_RESET.
  - All sticky bits, rx_valid and rx_byte = 0.
  - Both FSMs in IDLE; STATUS reads 32'h1.
- Reset taking effect mid-frame forces uart_tx_o high immediately and aborts RX.
- TX FIFO:
  - A push when full is dropped and sets tx_overflow. This applies even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 values wide.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - In IDLE with the FIFO not empty: pop into the shift register and enter START.
  - uart_tx_o falls on the second clock edge after the write edge, when the FIFO was empty and the FSM was IDLE.
  - Each bit lasts exactly `divisor` cycles. Data is sent LSB first, 8 bits, then one stop bit (high).
  - From STOP, the FSM returns to IDLE, and may pop again on the following edge. The minimum gap is one idle cycle.
- tx_busy = (state != IDLE) || !fifo_empty.
- A divisor write mid-frame takes effect at the next bit-counter reload; the current bit is not shortened.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer; all sampling uses the synchronized value.
  - States IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge (1 then 0) enters START.
  - START: after divisor/2 cycles, rounded down with a minimum of 1, sample the line. If high, it was a glitch: return to IDLE. If low, enter DATA.
  - DATA: sample every `divisor` cycles, 8 samples, LSB first.
  - STOP: sample after `divisor` cycles.
    - If the stop bit is high: load rx_byte and set rx_valid. If rx_valid was already 1, also set rx_overrun; rx_byte is overwritten.
    - If the stop bit is low: set rx_frame_err, discard the byte, and leave rx_valid unchanged.
  - The FSM returns to IDLE in both cases. A new start bit is only detected after a 1 is seen.
- A software rx_valid clear in the same cycle as a byte load: the load wins (rx_valid = 1), and overrun is not set.
- A sticky-bit clear in the same cycle as a set event: the set wins.

Decomposition:
- io_uart_pkg holds:
  - register offset constants (REG_TXDATA, REG_STATUS, REG_RXDATA, REG_BAUDDIV);
  - STATUS bit index constants;
  - the TX/RX FSM state encodings.
- One sub-module, uart_fifo: synchronous FIFO with push/pop/full/empty, parameterised by width 8 and FIFO_DEPTH, on the same clock and async active-low reset.
- The TX and RX FSMs stay inline in io_uart.

Test Plan:
- Reset: release reset_i and read offset 0x4 -> 32'h1. Read 0xC -> 234. uart_tx_o = 1.
- TX frame: write BAUDDIV = 4, then TXDATA = 0x55.
  - uart_tx_o low 2 edges after the write, for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then a 4-cycle stop high.
  - STATUS bit2 = 1 during the frame and 0 after the return to IDLE.
- TX overflow: with BAUDDIV = 4, write 0x00..0x11 on 18 consecutive cycles.
  - 0x00..0x10 are transmitted in order; 0x11 is dropped.
  - STATUS bit4 = 1; writing STATUS 0x10 clears it.
- RX receive: with BAUDDIV = 4, drive frame 0xA3 on uart_rx_i.
  - STATUS bit3 = 1 and RXDATA = 0xA3.
  - Drive 0x5C without clearing -> RXDATA = 0x5C and bit5 = 1. Writing RXDATA clears bit3.
- RX errors:
  - A 1-cycle low pulse on uart_rx_i -> no byte, STATUS unchanged.
  - A frame 0x3C with a low stop bit -> bit6 = 1 and bit3 unchanged.
- Async reset mid-TX: assert reset_i low during DATA of a 0x00 frame.
  - uart_tx_o = 1 before the next clk edge.
  - After release: STATUS = 32'h1, BAUDDIV = 234, and no residual transmission.
